// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, reset constants and PC type for the sorting core
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 64'h0;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef logic [XLEN-1:0] pc_t;

  function automatic logic is_word_aligned(input pc_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with redirect/hold/sequential select and misalign detect
module pc_register
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);

  logic target_ok;

  assign target_ok = is_word_aligned(branch_target);

  // A redirect outranks stall: the stalled instruction is being squashed anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (pc_src) begin
      if (target_ok) pc <= branch_target;
      else           misalign_err <= 1'b1;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage_pc.sv
// rtl/if_stage_pc.sv - instruction fetch stage: PC register plus IF/ID pipeline register
module if_stage_pc
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  input  logic [ILEN-1:0] instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ifid_pc,
  output logic [ILEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic            misalign_err
);

  pc_register u_pc_register (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_src        (pc_src),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .pc            (pc_out),
    .misalign_err  (misalign_err)
  );

  // Flush beats stall so a resolved branch always bubbles the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_pc    <= pc_out;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_pc    <= pc_out;
      ifid_instr <= instr_in;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_pc.sv
// tb/tb_if_stage_pc.sv - scoreboard bench for the fetch stage
module tb_if_stage_pc;
  import core_pkg::*;

  logic            clk = 1'b0;
  logic            reset, stall, flush, pc_src;
  logic [XLEN-1:0] pc_plus4, branch_target;
  logic [ILEN-1:0] instr_in;
  logic [XLEN-1:0] pc_out, ifid_pc;
  logic [ILEN-1:0] ifid_instr;
  logic            ifid_valid, misalign_err;
  logic            instr_mode;

  typedef struct {
    pc_t             pc;
    pc_t             ipc;
    logic [ILEN-1:0] instr;
    logic            valid;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   errors = 0;
  int   checks = 0;

  localparam logic [ILEN-1:0] BASE_INSTR = 32'h00A00093;

  always #5 clk = ~clk;

  // Model adder and model instruction memory, addressed by the live PC.
  assign pc_plus4 = pc_out + 64'd4;
  assign instr_in = instr_mode ? (BASE_INSTR ^ pc_out[31:0]) : BASE_INSTR;

  if_stage_pc dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_src        (pc_src),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .misalign_err  (misalign_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input logic src, input logic [XLEN-1:0] bt);
    exp_t            nx;
    exp_t            got;
    logic [ILEN-1:0] mem;
    reset = r; stall = s; flush = f; pc_src = src; branch_target = bt;
    mem = instr_mode ? (BASE_INSTR ^ m.pc[31:0]) : BASE_INSTR;
    nx = m;
    if (r) begin
      nx.pc = RESET_PC; nx.err = 1'b0;
      nx.ipc = '0; nx.instr = NOP_INSTR; nx.valid = 1'b0;
    end else begin
      if (src) begin
        if (bt[1:0] == 2'b00) nx.pc = bt;
        else                  nx.err = 1'b1;
      end else if (!s) nx.pc = m.pc + 64'd4;
      if (f) begin
        nx.ipc = m.pc; nx.instr = NOP_INSTR; nx.valid = 1'b0;
      end else if (!s) begin
        nx.ipc = m.pc; nx.instr = mem; nx.valid = 1'b1;
      end
    end
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, ".pc"},    pc_out,       got.pc);
    check({tag, ".ipc"},   ifid_pc,      got.ipc);
    check({tag, ".instr"}, {32'h0, ifid_instr}, {32'h0, got.instr});
    check({tag, ".valid"}, {63'h0, ifid_valid}, {63'h0, got.valid});
    check({tag, ".err"},   {63'h0, misalign_err}, {63'h0, got.err});
    m = got;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_mode = 1'b0;
    m = '{pc: '0, ipc: '0, instr: NOP_INSTR, valid: 1'b0, err: 1'b0};
    @(negedge clk);
    step("reset0", 1, 0, 0, 0, 64'h0);
    step("reset1", 1, 0, 0, 0, 64'h0);
    step("run1",   0, 0, 0, 0, 64'h0);
    step("run2",   0, 0, 0, 0, 64'h0);
    step("stall1", 0, 1, 0, 0, 64'h0);
    step("stall2", 0, 1, 0, 0, 64'h0);
    step("resume", 0, 0, 0, 0, 64'h0);
    step("run3",   0, 0, 0, 0, 64'h0);
    instr_mode = 1'b1;
    step("br40",   0, 0, 1, 1, 64'h40);
    step("run40",  0, 0, 0, 0, 64'h0);
    step("run44",  0, 0, 0, 0, 64'h0);
    step("brstl",  0, 1, 0, 1, 64'h100);
    step("run100", 0, 0, 0, 0, 64'h0);
    step("br20",   0, 0, 1, 1, 64'h20);
    step("mis102", 0, 0, 0, 1, 64'h102);
    step("run20",  0, 0, 0, 0, 64'h0);
    step("br200",  0, 0, 1, 1, 64'h200);
    step("run200", 0, 0, 0, 0, 64'h0);
    step("mis3st", 0, 1, 0, 1, 64'h203);
    step("fl_stl", 0, 1, 1, 0, 64'h0);
    step("brwrap", 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step("wrap0",  0, 0, 0, 0, 64'h0);
    step("wrap1",  0, 0, 0, 0, 64'h0);
    step("br80",   0, 0, 1, 1, 64'h80);
    step("stl80",  0, 1, 0, 0, 64'h0);
    step("rststl", 1, 1, 1, 1, 64'h300);
    step("post0",  0, 0, 0, 0, 64'h0);
    step("post1",  0, 0, 0, 0, 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
